// File: rtl/kfps2kb_xlat_fifo.sv
// PS/2 keyboard front end: F0/E0 prefix decode, optional set-2 to set-1
// translation, FIFO queueing, and IRQ1-style one-at-a-time presentation.
module kfps2kb_xlat_fifo #(
  parameter int         DEPTH      = 8,
  parameter bit         TRANSLATE  = 1'b1,
  parameter logic [7:0] PAUSE_CODE = 8'h07,
  parameter int         IRQ_GAP    = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  input  logic                     rx_error,
  output logic                     irq,
  output logic [7:0]               keycode,
  input  logic                     clear_keycode,
  output logic                     pause_core,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(IRQ_GAP + 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [GW-1:0] GAP_LOAD = GW'(IRQ_GAP);

  // Set-2 codes 00..7F to set-1; entry 0 is the leftmost byte.
  localparam logic [0:127][7:0] XLAT_TAB = {
    128'hff43413f3d3b3c58644442403e0f2959,
    128'h65382a701d10025a66712c1f1e11035b,
    128'h672e2d201205045c68392f211413065d,
    128'h693130232215075e6a7232241608095f,
    128'h6b332517180b0a606c34352627190c61,
    128'h6d7328741a0d626e3a361c1b752b6376,
    128'h55567778797a0e7b7c4f7d4b477e7f6f,
    128'h5253504c4d480145574e514a37494654
  };

  function automatic logic [7:0] xlat(input logic [7:0] c);
    if (c == 8'h83)
      xlat = 8'h41;
    else if (c[7])
      xlat = c;
    else
      xlat = XLAT_TAB[c[6:0]];
  endfunction

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [GW-1:0] gap_reg;
  logic          irq_reg, episode_reg, overrun_reg;
  logic [7:0]    head_reg;

  logic          hold_valid_reg, hold_err_reg;
  logic [7:0]    hold_data_reg;
  logic          pend_valid_reg;
  logic [7:0]    pend_data_reg;
  logic          brk_reg, ext_reg, pause_reg;

  logic          live_any, dec_go, dec_err, hold_load;
  logic [7:0]    dec_data;
  logic          push_req, pend_req;
  logic [7:0]    push_byte, pend_byte;
  logic          brk_next, ext_next, pause_next;
  logic          wr_req, pop, full, accept, ovf, mark, load;
  logic [7:0]    wr_byte;

  // A byte arriving while the second half of an E0 pair is still being
  // written is parked in the hold register and decoded afterwards.
  assign live_any  = rx_valid | rx_error;
  assign dec_go    = ~pend_valid_reg & (hold_valid_reg | live_any);
  assign dec_err   = hold_valid_reg ? hold_err_reg  : rx_error;
  assign dec_data  = hold_valid_reg ? hold_data_reg : rx_data;
  assign hold_load = live_any & (pend_valid_reg ? ~hold_valid_reg : hold_valid_reg);

  always_comb begin
    push_req   = 1'b0;
    push_byte  = 8'h00;
    pend_req   = 1'b0;
    pend_byte  = 8'h00;
    brk_next   = brk_reg;
    ext_next   = ext_reg;
    pause_next = pause_reg;
    if (dec_go) begin
      if (dec_err) begin
        push_req  = 1'b1;
        push_byte = 8'hFF;
        brk_next  = 1'b0;
        ext_next  = 1'b0;
      end else if (!TRANSLATE) begin
        if (dec_data != 8'hFA) begin
          push_req  = 1'b1;
          push_byte = dec_data;
          if (dec_data == 8'hF0) begin
            brk_next = 1'b1;
          end else begin
            if (dec_data == PAUSE_CODE && brk_reg)
              pause_next = ~pause_reg;
            brk_next = 1'b0;
          end
        end
      end else if (dec_data != 8'hFA && dec_data != 8'hE1) begin
        if (dec_data == 8'hF0) begin
          brk_next = 1'b1;
        end else if (dec_data == 8'hE0) begin
          ext_next = 1'b1;
        end else begin
          brk_next = 1'b0;
          ext_next = 1'b0;
          if (dec_data == PAUSE_CODE && !ext_reg) begin
            if (brk_reg)
              pause_next = ~pause_reg;
          end else if (!pause_reg) begin
            push_req = 1'b1;
            if (ext_reg) begin
              push_byte = 8'hE0;
              pend_req  = 1'b1;
              pend_byte = xlat(dec_data) | {brk_reg, 7'b0};
            end else begin
              push_byte = xlat(dec_data) | {brk_reg, 7'b0};
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid_reg <= 1'b0;
      hold_err_reg   <= 1'b0;
      hold_data_reg  <= 8'h00;
      pend_valid_reg <= 1'b0;
      pend_data_reg  <= 8'h00;
      brk_reg        <= 1'b0;
      ext_reg        <= 1'b0;
      pause_reg      <= 1'b0;
    end else begin
      if (hold_load) begin
        hold_valid_reg <= 1'b1;
        hold_err_reg   <= rx_error;
        hold_data_reg  <= rx_data;
      end else if (dec_go && hold_valid_reg) begin
        hold_valid_reg <= 1'b0;
      end
      pend_valid_reg <= pend_req;
      if (pend_req)
        pend_data_reg <= pend_byte;
      brk_reg   <= brk_next;
      ext_reg   <= ext_next;
      pause_reg <= pause_next;
    end
  end

  // A pop in the same cycle makes room, so a push into a full FIFO still lands.
  assign wr_req  = pend_valid_reg | push_req;
  assign wr_byte = pend_valid_reg ? pend_data_reg : push_byte;
  assign pop     = clear_keycode & irq_reg;
  assign full    = (count_reg == FULL);
  assign accept  = wr_req & (~full | pop);
  assign ovf     = wr_req & full & ~pop;
  assign mark    = ovf & ~episode_reg;
  assign load    = ~irq_reg & (gap_reg == '0) & (count_reg != '0);

  always_ff @(posedge clock) begin
    if (accept)
      mem[wr_ptr_reg] <= wr_byte;
    else if (mark)
      mem[wr_ptr_reg - 1'b1] <= 8'hFF;
    if (load)
      head_reg <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      gap_reg     <= '0;
      irq_reg     <= 1'b0;
      episode_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      if (accept)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(accept) - CW'(pop);

      if (mark)
        episode_reg <= 1'b1;
      else if (!full)
        episode_reg <= 1'b0;
      if (ovf)
        overrun_reg <= 1'b1;

      if (pop) begin
        irq_reg <= 1'b0;
        gap_reg <= GAP_LOAD;
      end else if (load) begin
        irq_reg <= 1'b1;
      end else if (!irq_reg && gap_reg != '0) begin
        gap_reg <= gap_reg - 1'b1;
      end
    end
  end

  assign irq        = irq_reg;
  assign keycode    = irq_reg ? head_reg : 8'h00;
  assign pause_core = pause_reg;
  assign fifo_count = count_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_kfps2kb_xlat_fifo.sv
// Bench for kfps2kb_xlat_fifo: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based reference model.
module tb_kfps2kb_xlat_fifo;

  localparam int         DEPTH   = 8;
  localparam int         IRQ_GAP = 4;
  localparam logic [7:0] PAUSE   = 8'h07;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic       rx_error = 1'b0;
  logic       clear_keycode = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       irq, pause_core, overrun;
  logic [7:0] keycode;
  logic [3:0] fifo_count;

  kfps2kb_xlat_fifo #(
    .DEPTH(DEPTH), .TRANSLATE(1'b1), .PAUSE_CODE(PAUSE), .IRQ_GAP(IRQ_GAP)
  ) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_error(rx_error), .irq(irq), .keycode(keycode),
    .clear_keycode(clear_keycode), .pause_core(pause_core),
    .fifo_count(fifo_count), .overrun(overrun)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Standard set-2 -> set-1 table for codes 00..7F.
  byte unsigned tab [128] = '{
    8'hFF,8'h43,8'h41,8'h3F,8'h3D,8'h3B,8'h3C,8'h58,8'h64,8'h44,8'h42,8'h40,8'h3E,8'h0F,8'h29,8'h59,
    8'h65,8'h38,8'h2A,8'h70,8'h1D,8'h10,8'h02,8'h5A,8'h66,8'h71,8'h2C,8'h1F,8'h1E,8'h11,8'h03,8'h5B,
    8'h67,8'h2E,8'h2D,8'h20,8'h12,8'h05,8'h04,8'h5C,8'h68,8'h39,8'h2F,8'h21,8'h14,8'h13,8'h06,8'h5D,
    8'h69,8'h31,8'h30,8'h23,8'h22,8'h15,8'h07,8'h5E,8'h6A,8'h72,8'h32,8'h24,8'h16,8'h08,8'h09,8'h5F,
    8'h6B,8'h33,8'h25,8'h17,8'h18,8'h0B,8'h0A,8'h60,8'h6C,8'h34,8'h35,8'h26,8'h27,8'h19,8'h0C,8'h61,
    8'h6D,8'h73,8'h28,8'h74,8'h1A,8'h0D,8'h62,8'h6E,8'h3A,8'h36,8'h1C,8'h1B,8'h75,8'h2B,8'h63,8'h76,
    8'h55,8'h56,8'h77,8'h78,8'h79,8'h7A,8'h0E,8'h7B,8'h7C,8'h4F,8'h7D,8'h4B,8'h47,8'h7E,8'h7F,8'h6F,
    8'h52,8'h53,8'h50,8'h4C,8'h4D,8'h48,8'h01,8'h45,8'h57,8'h4E,8'h51,8'h4A,8'h37,8'h49,8'h46,8'h54
  };

  logic [7:0] make_codes [10] = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45};
  logic [7:0] make_set1  [10] = '{8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,8'h09,8'h0A,8'h0B};

  function automatic byte unsigned set1_of(input byte unsigned c);
    if (c >= 8'h84) return c;
    if (c == 8'h83) return 8'h41;
    if (c >= 8'h80) return c;
    return tab[c];
  endfunction

  // ---------------- reference model ----------------
  byte unsigned mq[$];   // queued bytes, head first
  byte unsigned wq[$];   // decoded bytes still to be written, one per cycle
  bit m_irq = 0, m_ovr = 0, m_epi = 0, m_brk = 0, m_ext = 0, m_pause = 0;
  int m_gap = 0;

  task automatic m_reset();
    mq.delete(); wq.delete();
    m_irq = 0; m_ovr = 0; m_epi = 0; m_brk = 0; m_ext = 0; m_pause = 0; m_gap = 0;
  endtask

  task automatic m_decode(input bit err, input byte unsigned c);
    if (err) begin
      m_brk = 0; m_ext = 0; wq.push_back(8'hFF);
    end else if (c == 8'hFA || c == 8'hE1) begin
      m_brk = m_brk;
    end else if (c == 8'hF0) begin
      m_brk = 1;
    end else if (c == 8'hE0) begin
      m_ext = 1;
    end else begin
      if (c == PAUSE && !m_ext) begin
        if (m_brk) m_pause = !m_pause;
      end else if (!m_pause) begin
        if (m_ext) wq.push_back(8'hE0);
        wq.push_back(set1_of(c) | (m_brk ? 8'h80 : 8'h00));
      end
      m_brk = 0; m_ext = 0;
    end
  endtask

  task automatic m_step();
    int  n;
    bit  pop;
    byte unsigned b;
    n   = mq.size();
    pop = clear_keycode && m_irq;
    if (pop) begin
      m_irq = 0; m_gap = IRQ_GAP;
    end else if (!m_irq) begin
      if (m_gap > 0) m_gap--;
      else if (n > 0) m_irq = 1;
    end
    if (rx_valid || rx_error) m_decode(rx_error, rx_data);
    if (pop) void'(mq.pop_front());
    if (wq.size() > 0) begin
      b = wq.pop_front();
      if (n < DEPTH || pop) begin
        mq.push_back(b);
        if (n < DEPTH) m_epi = 0;
      end else begin
        m_ovr = 1;
        if (!m_epi) begin mq[mq.size()-1] = 8'hFF; m_epi = 1; end
      end
    end else if (n < DEPTH) begin
      m_epi = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) m_reset();
      else m_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    logic [7:0] exp_kc;
    @(negedge reset);
    forever begin
      @(negedge clock);
      exp_kc = m_irq ? mq[0] : 8'h00;
      tests++;
      if ({irq, keycode, fifo_count, overrun, pause_core} !==
          {m_irq, exp_kc, 4'(mq.size()), m_ovr, m_pause}) begin
        fails++;
        if (fails < 20)
          $display("FAIL model_cmp t=%0t irq/kc/cnt/ovr/pause got %b/%h/%0d/%b/%b expected %b/%h/%0d/%b/%b",
                   $time, irq, keycode, fifo_count, overrun, pause_core,
                   m_irq, exp_kc, mq.size(), m_ovr, m_pause);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clock); #1 rx_valid = 1'b1; rx_data = b;
    @(negedge clock); #1 rx_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic send_err();
    @(negedge clock); #1 rx_error = 1'b1;
    @(negedge clock); #1 rx_error = 1'b0;
    @(negedge clock);
  endtask

  task automatic pulse_clear();
    @(negedge clock); #1 clear_keycode = 1'b1;
    @(negedge clock); #1 clear_keycode = 1'b0;
  endtask

  task automatic wait_irq(input string name);
    int waited = 0;
    while (irq !== 1'b1 && waited < 64) begin
      @(negedge clock);
      waited++;
    end
    if (irq !== 1'b1) begin
      tests++; fails++;
      $display("FAIL %s: irq wait expired, got %b expected 1", name, irq);
    end
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    wait_irq(name);
    check(name, 32'(keycode), 32'(exp));
    pulse_clear();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lows;
    int cool;
    int r;
    idle(3);
    check("reset_irq", 32'(irq), 0);
    check("reset_keycode", 32'(keycode), 0);
    check("reset_count", 32'(fifo_count), 0);
    check("reset_overrun", 32'(overrun), 0);
    check("reset_pause", 32'(pause_core), 0);
    #1 reset = 1'b0;
    idle(2);

    // make then break with the IRQ gap between presentations
    send(8'h1C); send(8'hF0); send(8'h1C);
    pop_expect("make_1C", 8'h1E);
    lows = 1;
    @(negedge clock);
    while (irq !== 1'b1 && lows < 64) begin lows++; @(negedge clock); end
    tests++;
    if (lows < IRQ_GAP) begin
      fails++;
      $display("FAIL irq_gap: got %0d low cycles expected at least %0d", lows, IRQ_GAP);
    end
    check("break_1C", 32'(keycode), 32'h9E);
    pulse_clear();
    idle(8);

    // extended make and break, queued without clears
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    idle(3);
    check("ext_count", 32'(fifo_count), 4);
    check("model_q_len", 32'(mq.size()), 4);
    check("model_q1", 32'(mq[1]), 32'h48);
    check("model_q3", 32'(mq[3]), 32'hC8);
    pop_expect("ext_pop0", 8'hE0);
    pop_expect("ext_pop1", 8'h48);
    pop_expect("ext_pop2", 8'hE0);
    pop_expect("ext_pop3", 8'hC8);
    idle(8);

    // ACK dropped, error queues FF
    send(8'hFA);
    idle(3);
    check("ack_no_irq", 32'(irq), 0);
    check("ack_no_count", 32'(fifo_count), 0);
    send_err();
    idle(2);
    check("err_count", 32'(fifo_count), 1);
    pop_expect("err_ff", 8'hFF);
    idle(8);

    // pause toggle on F12 release
    send(8'hF0); send(PAUSE);
    check("pause_on", 32'(pause_core), 1);
    send(8'h1C);
    idle(3);
    check("paused_drop", 32'(fifo_count), 0);
    send(8'hF0); send(PAUSE);
    check("pause_off", 32'(pause_core), 0);
    send(8'h1C);
    pop_expect("after_pause", 8'h1E);
    idle(8);

    // overflow: 10 makes into 8 entries
    for (int i = 0; i < 10; i++) send(make_codes[i]);
    idle(3);
    check("ovf_count", 32'(fifo_count), DEPTH);
    check("ovf_flag", 32'(overrun), 1);
    check("model_ovf_flag", 32'(m_ovr), 1);
    check("model_ovf_last", 32'(mq[DEPTH-1]), 32'hFF);
    for (int i = 0; i < DEPTH - 1; i++) pop_expect($sformatf("ovf_pop%0d", i), make_set1[i]);
    pop_expect("ovf_marker", 8'hFF);
    idle(8);
    check("ovf_sticky", 32'(overrun), 1);

    // reset while the second byte of an E0 pair is pending
    send(8'hE0);
    @(negedge clock); #1 rx_valid = 1'b1; rx_data = 8'h75;
    @(negedge clock); #1 rx_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    check("rst_irq", 32'(irq), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_overrun", 32'(overrun), 0);
    #1 reset = 1'b0;
    idle(3);
    send(8'h1C);
    wait_irq("rst_after");
    check("rst_after_count", 32'(fifo_count), 1);
    pop_expect("rst_after_kc", 8'h1E);
    idle(8);

    // randomized traffic, checked by the per-cycle model compare
    cool = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock); #1;
      rx_valid = 1'b0;
      rx_error = 1'b0;
      clear_keycode = ($urandom_range(0, 3) == 0);
      if (cool > 0) begin
        cool--;
      end else if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 19);
        cool = 1;
        if (r == 8) begin
          rx_error = 1'b1;
        end else begin
          rx_valid = 1'b1;
          case (r)
            0, 1, 2: rx_data = 8'hF0;
            3, 4:    rx_data = 8'hE0;
            5:       rx_data = 8'hFA;
            6:       rx_data = 8'hE1;
            7:       rx_data = PAUSE;
            default: rx_data = 8'($urandom_range(0, 8'h8F));
          endcase
        end
      end
    end
    @(negedge clock); #1;
    rx_valid = 1'b0; rx_error = 1'b0; clear_keycode = 1'b0;
    idle(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
